// File: rtl/envelope_sequencer.sv
// Attack/sustain/decay gain envelope driven solely by the sample tick.
// Linear attack up to 8/8, timed hold, then decay steps at doubling intervals.
module envelope_sequencer #(
  parameter int ATTACK_PERIOD = 4,
  parameter int HOLD_SCALE    = 16,
  parameter int BASE_PERIOD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_start,
  input  logic [5:0] note_duration,
  input  logic       generate_next_sample,
  output logic [3:0] gain,
  output logic       envelope_active,
  output logic       note_done
);

  localparam int HOLD_MAX  = 63 * HOLD_SCALE;
  // Decay interval doubles once more on the final step, so size for 256x.
  localparam int DECAY_MAX = BASE_PERIOD * 256;
  localparam int MAX_AH    = (ATTACK_PERIOD > HOLD_MAX) ? ATTACK_PERIOD : HOLD_MAX;
  localparam int CNT_MAX   = (MAX_AH > DECAY_MAX) ? MAX_AH : DECAY_MAX;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_DECAY   = 2'd3;

  localparam logic [3:0] GAIN_FULL = 4'd8;

  logic [1:0]    state_q, state_d;
  logic [3:0]    gain_q, gain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] interval_q, interval_d;
  logic [5:0]    dur_q, dur_d;
  logic          note_done_q, note_done_d;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hold_ticks;

  assign cnt_inc    = cnt_q + CW'(1);
  assign hold_ticks = CW'(dur_q) * CW'(HOLD_SCALE);

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cnt_d       = cnt_q;
    interval_d  = interval_q;
    dur_d       = dur_q;
    note_done_d = 1'b0;

    // A new note always wins over a coincident tick, which is then dropped.
    if (note_start) begin
      state_d = S_ATTACK;
      cnt_d   = '0;
      dur_d   = note_duration;
    end else begin
      case (state_q)
        S_ATTACK: begin
          if (generate_next_sample && gain_q < GAIN_FULL) begin
            if (cnt_inc == CW'(ATTACK_PERIOD)) begin
              gain_d = gain_q + 4'd1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          // Also covers a retrigger that arrived with gain already full.
          if (gain_d == GAIN_FULL) begin
            cnt_d      = '0;
            interval_d = CW'(BASE_PERIOD);
            state_d    = (dur_q == 6'd0) ? S_DECAY : S_SUSTAIN;
          end
        end
        S_SUSTAIN: begin
          if (generate_next_sample) begin
            if (cnt_inc == hold_ticks) begin
              cnt_d      = '0;
              interval_d = CW'(BASE_PERIOD);
              state_d    = S_DECAY;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_DECAY: begin
          if (generate_next_sample && gain_q != 4'd0) begin
            if (cnt_inc == interval_q) begin
              gain_d     = gain_q - 4'd1;
              interval_d = interval_q << 1;
              cnt_d      = '0;
              if (gain_q == 4'd1) begin
                state_d     = S_IDLE;
                note_done_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          gain_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gain_q      <= 4'd0;
      cnt_q       <= '0;
      interval_q  <= '0;
      dur_q       <= 6'd0;
      note_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      cnt_q       <= cnt_d;
      interval_q  <= interval_d;
      dur_q       <= dur_d;
      note_done_q <= note_done_d;
    end
  end

  assign gain            = gain_q;
  assign envelope_active = (state_q != S_IDLE);
  assign note_done       = note_done_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer with default parameters; expected
// gains come from the documented attack/hold/decay tick schedule.
module tb_envelope_sequencer;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       note_start;
  logic [5:0] note_duration;
  logic       generate_next_sample;
  logic [3:0] gain;
  logic       envelope_active;
  logic       note_done;

  int n_checks;
  int n_fail;

  envelope_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .note_start           (note_start),
    .note_duration        (note_duration),
    .generate_next_sample (generate_next_sample),
    .gain                 (gain),
    .envelope_active      (envelope_active),
    .note_done            (note_done)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Expected gain after tick t of a note that starts attacking from g0.
  // Decay steps fall at cumulative ticks 2*(2^k-1), k=1..8.
  function automatic int exp_gain(input int t, input int g0, input int dur);
    int al, a, g;
    al = (8 - g0) * 4;
    if (t < al) return g0 + t / 4;
    a = al + dur * 16;
    if (t <= a) return 8;
    g = 8;
    for (int k = 1; k <= 8; k++)
      if (t - a >= 2 * ((1 << k) - 1)) g--;
    return g;
  endfunction

  task automatic cyc(input logic tk);
    generate_next_sample = tk;
    @(posedge clk);
    #1;
    generate_next_sample = 1'b0;
    note_start           = 1'b0;
  endtask

  task automatic start_note(input logic [5:0] dur, input logic tk);
    note_start    = 1'b1;
    note_duration = dur;
    cyc(tk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    reset  = 1'b0;
    #3;
    n_checks++;
    if (gain !== 4'd0 || envelope_active !== 1'b0 || note_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_clock gain=%0d act=%0b done=%0b expected 0/0/0", gain, envelope_active, note_done);
    end
    reset  = 1'b1;
    clk_en = 1'b1;
    cyc(1'b0);
    start_note(6'd2, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1);
    n_checks++;
    if (gain !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_pre_gain gain=%0d expected 2", gain);
    end
    @(negedge clk);
    #1 clk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (gain !== 4'd0 || envelope_active !== 1'b0 || note_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stopped_clk gain=%0d act=%0b done=%0b expected 0/0/0", gain, envelope_active, note_done);
    end
    #5 reset = 1'b1;
    clk_en = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    n_checks++;
    if (gain !== 4'd0 || envelope_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_waits_idle gain=%0d act=%0b expected 0/0", gain, envelope_active);
    end
  endtask

  task automatic test_idle_ticks();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      n_checks++;
      if (gain !== 4'd0 || envelope_active !== 1'b0 || note_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ticks i=%0d gain=%0d act=%0b done=%0b expected 0/0/0", i, gain, envelope_active, note_done);
      end
    end
  endtask

  // Full note with tick every cycle: checks all three outputs at every tick.
  task automatic test_full_note(input logic [5:0] dur, input string nm);
    int       t_end;
    logic [3:0] eg;
    t_end = 32 + int'(dur) * 16 + 510;
    start_note(dur, 1'b0);
    n_checks++;
    if (gain !== 4'd0 || envelope_active !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start gain=%0d act=%0b expected 0/1", nm, gain, envelope_active);
    end
    for (int t = 1; t <= t_end + 1; t++) begin
      cyc(1'b1);
      eg = 4'(exp_gain(t, 0, int'(dur)));
      n_checks++;
      if (gain !== eg || envelope_active !== (t < t_end) || note_done !== (t == t_end)) begin
        n_fail++;
        $display("FAIL %s t=%0d gain=%0d act=%0b done=%0b expected %0d/%0b/%0b",
                 nm, t, gain, envelope_active, note_done, eg, (t < t_end), (t == t_end));
      end
    end
  endtask

  task automatic test_retrigger_decay();
    int       t_end;
    logic [3:0] eg;
    start_note(6'd3, 1'b0);
    for (int t = 1; t <= 94; t++) cyc(1'b1);
    n_checks++;
    if (gain !== 4'd5) begin
      n_fail++;
      $display("FAIL retrig_pre gain=%0d expected 5", gain);
    end
    start_note(6'd3, 1'b0);
    n_checks++;
    if (gain !== 4'd5 || envelope_active !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_hold gain=%0d act=%0b expected 5/1", gain, envelope_active);
    end
    t_end = 12 + 48 + 510;
    for (int t = 1; t <= t_end + 1; t++) begin
      cyc(1'b1);
      eg = 4'(exp_gain(t, 5, 3));
      n_checks++;
      if (gain !== eg || envelope_active !== (t < t_end) || note_done !== (t == t_end)) begin
        n_fail++;
        $display("FAIL retrig t=%0d gain=%0d act=%0b done=%0b expected %0d/%0b/%0b",
                 t, gain, envelope_active, note_done, eg, (t < t_end), (t == t_end));
      end
    end
  endtask

  task automatic test_retrigger_full();
    logic [3:0] eg;
    start_note(6'd1, 1'b0);
    for (int t = 1; t <= 37; t++) cyc(1'b1);
    start_note(6'd1, 1'b0);
    cyc(1'b0);
    n_checks++;
    if (gain !== 4'd8 || envelope_active !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_full_hold gain=%0d act=%0b expected 8/1", gain, envelope_active);
    end
    for (int t = 1; t <= 20; t++) begin
      cyc(1'b1);
      eg = 4'(exp_gain(t, 8, 1));
      n_checks++;
      if (gain !== eg || note_done !== 1'b0) begin
        n_fail++;
        $display("FAIL retrig_full t=%0d gain=%0d done=%0b expected %0d/0", t, gain, note_done, eg);
      end
    end
    pulse_reset();
  endtask

  task automatic test_coincident_tick();
    start_note(6'd3, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      cyc(1'b1);
      n_checks++;
      if (gain !== ((t == 4) ? 4'd1 : 4'd0)) begin
        n_fail++;
        $display("FAIL coincident t=%0d gain=%0d expected %0d", t, gain, (t == 4) ? 1 : 0);
      end
    end
    pulse_reset();
  endtask

  task automatic test_reset_mid_decay();
    start_note(6'd0, 1'b0);
    for (int t = 1; t <= 94; t++) cyc(1'b1);
    n_checks++;
    if (gain !== 4'd3) begin
      n_fail++;
      $display("FAIL rst_decay_pre gain=%0d expected 3", gain);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (gain !== 4'd0 || envelope_active !== 1'b0 || note_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_decay_async gain=%0d act=%0b done=%0b expected 0/0/0", gain, envelope_active, note_done);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1);
      n_checks++;
      if (gain !== 4'd0 || envelope_active !== 1'b0 || note_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_decay_after i=%0d gain=%0d act=%0b done=%0b expected 0/0/0",
                 i, gain, envelope_active, note_done);
      end
    end
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    note_start           = 1'b0;
    note_duration        = 6'd0;
    generate_next_sample = 1'b0;
    test_reset();
    test_idle_ticks();
    test_full_note(6'd3, "note_dur3");
    test_full_note(6'd0, "note_dur0");
    test_retrigger_decay();
    test_retrigger_full();
    test_coincident_tick();
    test_reset_mid_decay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
